// File: rtl/pacman_behavior_if.sv
// Handshake and data bundle between the host and the Pac-Man movement controller.
interface pacman_behavior_if;
  logic       start;
  logic       ready;
  logic       up;
  logic       down;
  logic       left;
  logic       right;
  logic [9:0] curr_block;
  logic [9:0] next_block;
  logic       done;

  modport master (
    output start, up, down, left, right, curr_block,
    input  ready, next_block, done
  );

  modport slave (
    input  start, up, down, left, right, curr_block,
    output ready, next_block, done
  );
endinterface

// File: rtl/pacman_behavior.sv
// Periodic movement controller for the Pac-Man sprite on a 32x32 block maze.
// Optional feature: define PACMAN_TUNNEL_EN to open the row-15 side tunnel (480 <-> 511).
module pacman_behavior #(
  parameter int unsigned MOVE_DIV    = 6,
  parameter logic [9:0]  START_BLOCK = 10'd495
) (
  input logic            clk,
  input logic            reset,
  pacman_behavior_if.slave ctrl
);

  localparam int CNT_W = $clog2(MOVE_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOVE_DIV - 1);

  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic [2:0] {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;
  typedef struct packed {
    logic       legal;
    logic [9:0] target;
  } move_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt_p0;
  logic             tick;
  logic             ready;

  dir_t       req;
  move_t      req_mv, dir_mv;
  logic [9:0] step_block;
  dir_t       step_dir;

  logic [9:0] next_block_p0;
  dir_t       dir_p0;
  logic       vld_p0;

  // Border ring is solid; the tunnel mouths are carved out when enabled.
  function automatic logic is_wall(input logic [9:0] idx);
    logic w;
    w = (idx[9:5] == 5'd0) || (idx[9:5] == 5'd31) ||
        (idx[4:0] == 5'd0) || (idx[4:0] == 5'd31);
`ifdef PACMAN_TUNNEL_EN
    if (idx == 10'd480 || idx == 10'd511) w = 1'b0;
`endif
    return w;
  endfunction

  function automatic move_t try_move(input logic [9:0] idx, input dir_t d);
    move_t m;
    m.legal  = 1'b0;
    m.target = idx;
    case (d)
      DIR_UP: if (idx[9:5] != 5'd0) begin
        m.target = idx - 10'd32;
        m.legal  = !is_wall(m.target);
      end
      DIR_DOWN: if (idx[9:5] != 5'd31) begin
        m.target = idx + 10'd32;
        m.legal  = !is_wall(m.target);
      end
      DIR_LEFT: begin
        if (idx[4:0] != 5'd0) begin
          m.target = idx - 10'd1;
          m.legal  = !is_wall(m.target);
        end
`ifdef PACMAN_TUNNEL_EN
        if (idx == 10'd480) begin
          m.target = 10'd511;
          m.legal  = 1'b1;
        end
`endif
      end
      DIR_RIGHT: begin
        if (idx[4:0] != 5'd31) begin
          m.target = idx + 10'd1;
          m.legal  = !is_wall(m.target);
        end
`ifdef PACMAN_TUNNEL_EN
        if (idx == 10'd511) begin
          m.target = 10'd480;
          m.legal  = 1'b1;
        end
`endif
      end
      default: ;
    endcase
    return m;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == IDLE && ctrl.start) state_nxt = RUN;
  end

  always_comb begin
    ready = (state == IDLE);
    tick  = (state == RUN) && (cnt_p0 == CNT_LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              cnt_p0 <= '0;
    else if (state != RUN)   cnt_p0 <= '0;
    else if (tick)           cnt_p0 <= '0;
    else                     cnt_p0 <= cnt_p0 + CNT_W'(1);
  end

  // Decision: held request first, then coast in the last direction, else stop.
  always_comb begin
    req = DIR_NONE;
    if      (ctrl.up)    req = DIR_UP;
    else if (ctrl.down)  req = DIR_DOWN;
    else if (ctrl.left)  req = DIR_LEFT;
    else if (ctrl.right) req = DIR_RIGHT;

    req_mv     = try_move(ctrl.curr_block, req);
    dir_mv     = try_move(ctrl.curr_block, dir_p0);
    step_block = ctrl.curr_block;
    step_dir   = DIR_NONE;
    if (req != DIR_NONE && req_mv.legal) begin
      step_block = req_mv.target;
      step_dir   = req;
    end else if (dir_p0 != DIR_NONE && dir_mv.legal) begin
      step_block = dir_mv.target;
      step_dir   = dir_p0;
    end
  end

  // Stage p0: result registered on the tick edge together with its pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      next_block_p0 <= START_BLOCK;
      dir_p0        <= DIR_NONE;
      vld_p0        <= 1'b0;
    end else begin
      vld_p0 <= tick;
      if (tick) begin
        next_block_p0 <= step_block;
        dir_p0        <= step_dir;
      end
    end
  end

  assign ctrl.ready      = ready;
  assign ctrl.next_block = next_block_p0;
  assign ctrl.done       = vld_p0;

endmodule

// File: tb/tb_pacman_behavior.sv
// Randomized self-checking bench for pacman_behavior against a grid-rule model.
module tb_pacman_behavior;
  localparam int MD    = 6;
  localparam int START = 495;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_dir;   // 0 none, 1 up, 2 down, 3 left, 4 right
  int   m_next;

  pacman_behavior_if ifc();

  pacman_behavior #(.MOVE_DIV(MD), .START_BLOCK(10'd495)) dut (
    .clk  (clk),
    .reset(reset),
    .ctrl (ifc.slave)
  );

  always #5 clk = ~clk;

  function automatic bit tunnel_on();
`ifdef PACMAN_TUNNEL_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_wall(int r, int c);
    if (tunnel_on() && r == 15 && (c == 0 || c == 31)) return 1'b0;
    return (r == 0 || r == 31 || c == 0 || c == 31);
  endfunction

  function automatic bit m_try(int cur, int d, output int tgt);
    int r, c, nr, nc;
    r = cur / 32; c = cur % 32; nr = r; nc = c; tgt = cur;
    case (d)
      1: nr = r - 1;
      2: nr = r + 1;
      3: nc = c - 1;
      4: nc = c + 1;
      default: return 1'b0;
    endcase
    if (tunnel_on() && r == 15 && nc == -1) nc = 31;
    if (tunnel_on() && r == 15 && nc == 32) nc = 0;
    if (nr < 0 || nr > 31 || nc < 0 || nc > 31) return 1'b0;
    tgt = nr * 32 + nc;
    return !m_wall(nr, nc);
  endfunction

  function automatic void m_step(int cur, bit u, bit d, bit l, bit r);
    int req, tgt;
    req = u ? 1 : d ? 2 : l ? 3 : r ? 4 : 0;
    if (req != 0 && m_try(cur, req, tgt)) begin
      m_next = tgt; m_dir = req;
    end else if (m_dir != 0 && m_try(cur, m_dir, tgt)) begin
      m_next = tgt;
    end else begin
      m_next = cur; m_dir = 0;
    end
  endfunction

  task automatic drive(int cur, bit u, bit d, bit l, bit r, bit st);
    ifc.curr_block = 10'(cur);
    ifc.up = u; ifc.down = d; ifc.left = l; ifc.right = r;
    ifc.start = st;
  endtask

  // Entered just after an edge where the step counter is 0 in RUN.
  task automatic do_step(string name, int cur, bit u, bit d, bit l, bit r, bit scramble);
    int k; bit hold_ok; int prev; logic [31:0] rnd;
    prev = m_next; hold_ok = 1'b1; k = 0;
    do begin
      k++;
      if (scramble && k < MD) begin
        rnd = $urandom;
        drive(int'(rnd[9:0]), rnd[10], rnd[11], rnd[12], rnd[13], rnd[14]);
      end else drive(cur, u, d, l, r, 1'b0);
      @(posedge clk); #1;
      if (!ifc.done && ifc.next_block !== 10'(prev)) hold_ok = 1'b0;
    end while (!ifc.done && k < MD + 4);
    m_step(cur, u, d, l, r);
    n_cmp++;
    if (k !== MD || ifc.done !== 1'b1) begin
      n_err++;
      $display("FAIL %s timing: done=%b after %0d cycles, required done=1 after %0d", name, ifc.done, k, MD);
    end
    n_cmp++;
    if (ifc.next_block !== 10'(m_next)) begin
      n_err++;
      $display("FAIL %s next_block: got %0d, required %0d (curr=%0d udlr=%b%b%b%b)", name, ifc.next_block, m_next, cur, u, d, l, r);
    end
    n_cmp++;
    if (!hold_ok || ifc.ready !== 1'b0) begin
      n_err++;
      $display("FAIL %s hold/ready: hold_ok=%b ready=%b, required hold_ok=1 ready=0", name, hold_ok, ifc.ready);
    end
  endtask

  task automatic start_run();
    ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    n_cmp++;
    if (ifc.ready !== 1'b0) begin
      n_err++;
      $display("FAIL start_ready: got %b, required 0", ifc.ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(START, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk); #1;
    n_cmp++;
    if (ifc.ready !== 1'b1 || ifc.done !== 1'b0 || ifc.next_block !== 10'(START)) begin
      n_err++;
      $display("FAIL reset_state: ready=%b done=%b next=%0d, required 1 0 %0d", ifc.ready, ifc.done, ifc.next_block, START);
    end
    reset = 1'b1; m_dir = 0; m_next = START;
    repeat (MD + 2) @(posedge clk); #1;
    n_cmp++;
    if (ifc.ready !== 1'b1 || ifc.done !== 1'b0 || ifc.next_block !== 10'(START)) begin
      n_err++;
      $display("FAIL idle_hold: ready=%b done=%b next=%0d, required 1 0 %0d", ifc.ready, ifc.done, ifc.next_block, START);
    end
  endtask

  task automatic test_basic_moves();
    drive(495, 1, 0, 0, 0, 0);
    start_run();
    do_step("up_495", 495, 1, 0, 0, 0, 0);
    do_step("right_495", 495, 0, 0, 0, 1, 0);
    for (int b = 496; b <= 501; b++) do_step("right_walk", b, 0, 0, 0, 1, 0);
    do_step("down_495", 495, 0, 1, 0, 0, 0);
    do_step("left_294", 294, 0, 0, 1, 0, 0);
  endtask

  task automatic test_coast_and_block();
    do_step("right_again", 495, 0, 0, 0, 1, 0);
    do_step("coast_right", 495, 0, 0, 0, 0, 0);
    do_step("up_33_coast", 33, 1, 0, 0, 0, 0);
    do_step("left_33_coast", 33, 0, 0, 1, 0, 0);
    do_step("right_62_wall", 62, 0, 0, 0, 1, 0);
    do_step("idle_33", 33, 0, 0, 0, 0, 0);
    do_step("up_33_block", 33, 1, 0, 0, 0, 0);
    do_step("left_33_block", 33, 0, 0, 1, 0, 0);
  endtask

  task automatic test_priority();
    do_step("up_right", 495, 1, 0, 0, 1, 0);
    do_step("down_left", 495, 0, 1, 1, 1, 0);
    do_step("left_right", 495, 0, 0, 1, 1, 0);
  endtask

  task automatic test_tunnel();
    do_step("left_481", 481, 0, 0, 1, 0, 0);
    do_step("left_480", 480, 0, 0, 1, 0, 0);
    do_step("right_511", 511, 0, 0, 0, 1, 0);
    do_step("coast_511", 511, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    int picks[8] = '{480, 481, 510, 511, 33, 62, 961, 990};
    int cur; logic [31:0] rnd;
    for (int i = 0; i < 40; i++) begin
      rnd = $urandom;
      cur = (rnd[1:0] == 2'd0) ? picks[rnd[4:2]] : int'(rnd[14:5]);
      do_step("random", cur, rnd[15] & rnd[16], rnd[17] & rnd[18], rnd[19], rnd[20], 1'b1);
    end
  endtask

  task automatic test_reset_mid_run();
    do_step("pre_reset", 495, 1, 0, 0, 0, 0);
    #1 reset = 1'b0;
    #1;
    n_cmp++;
    if (ifc.ready !== 1'b1 || ifc.done !== 1'b0 || ifc.next_block !== 10'(START)) begin
      n_err++;
      $display("FAIL async_reset: ready=%b done=%b next=%0d, required 1 0 %0d", ifc.ready, ifc.done, ifc.next_block, START);
    end
    m_dir = 0; m_next = START;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    drive(600, 0, 0, 0, 0, 0);
    start_run();
    do_step("no_coast_after_reset", 600, 0, 0, 0, 0, 0);
  endtask

  initial begin
    drive(START, 0, 0, 0, 0, 0);
    test_reset();
    test_basic_moves();
    test_coast_and_block();
    test_priority();
    test_tunnel();
    test_random();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
